// File: rtl/divr4_seq.sv
// Sequential restoring radix-4 unsigned divider: STAGES radix-4 steps per clock, N = W/(2*STAGES) cycles.
// Optional: define DIVR4_SEQ_EARLY_EXIT_EN to finish in one cycle when i_a < i_b (i_b != 0).
module divr4_seq #(
   parameter int W      = 64,
   parameter int STAGES = 4
) (
   input  logic         i_clk,
   input  logic         i_nrst,
   input  logic         i_ena,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_busy,
   output logic         o_valid,
   output logic [W-1:0] o_quot,
   output logic [W-1:0] o_rem,
   output logic         o_dzero
);

   localparam int N  = W / (2 * STAGES);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t          state_q, state_d;
   logic            accept, finish, early;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    dq_q, dq_nx;     // dividend shifts out the top while quotient digits shift in below
   logic [W-1:0]    rem_q, rem_nx;
   logic [W+1:0]    b1_q, b2_q, b3_q;
   logic            bz_q;

   // Iteration temporaries
   logic [W+1:0]    t;
   logic [W+2:0]    d1, d2, d3;
   logic [1:0]      dig;

`ifdef DIVR4_SEQ_EARLY_EXIT_EN
   assign early = (i_b != '0) && (i_a < i_b);
`else
   assign early = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // NOTE: every variable written here is given a default first, so no latch can be inferred.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      finish  = 1'b0;
      o_busy  = 1'b0;
      o_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_ena) begin
               accept  = 1'b1;
               state_d = early ? S_DONE : S_ITER;
            end
         end
         S_ITER: begin
            o_busy = 1'b1;
            if (cnt_q == LAST) begin
               finish  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            o_valid = 1'b1;
            state_d = S_IDLE;
            if (i_ena) begin
               accept  = 1'b1;
               state_d = early ? S_DONE : S_ITER;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // STAGES chained restoring radix-4 steps; a zero divisor naturally yields all-ones digits and rem = a.
   always_comb begin
      dq_nx  = dq_q;
      rem_nx = rem_q;
      t      = '0;
      d1     = '0;
      d2     = '0;
      d3     = '0;
      dig    = 2'd0;
      for (int s = 0; s < STAGES; s++) begin
         t  = {rem_nx, dq_nx[W-1 -: 2]};
         d3 = {1'b0, t} - {1'b0, b3_q};
         d2 = {1'b0, t} - {1'b0, b2_q};
         d1 = {1'b0, t} - {1'b0, b1_q};
         if (!d3[W+2]) begin
            dig    = 2'd3;
            rem_nx = d3[W-1:0];
         end else if (!d2[W+2]) begin
            dig    = 2'd2;
            rem_nx = d2[W-1:0];
         end else if (!d1[W+2]) begin
            dig    = 2'd1;
            rem_nx = d1[W-1:0];
         end else begin
            dig    = 2'd0;
            rem_nx = t[W-1:0];
         end
         dq_nx = {dq_nx[W-3:0], dig};
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         cnt_q   <= '0;
         dq_q    <= '0;
         rem_q   <= '0;
         b1_q    <= '0;
         b2_q    <= '0;
         b3_q    <= '0;
         bz_q    <= 1'b0;
         o_quot  <= '0;
         o_rem   <= '0;
         o_dzero <= 1'b0;
      end else if (accept) begin
         cnt_q <= '0;
         dq_q  <= i_a;
         rem_q <= '0;
         b1_q  <= {2'b00, i_b};
         b2_q  <= {1'b0, i_b, 1'b0};
         b3_q  <= {2'b00, i_b} + {1'b0, i_b, 1'b0};
         bz_q  <= (i_b == '0);
         if (early) begin
            o_quot  <= '0;
            o_rem   <= i_a;
            o_dzero <= 1'b0;
         end
      end else if (state_q == S_ITER) begin
         cnt_q <= cnt_q + 1'b1;
         dq_q  <= dq_nx;
         rem_q <= rem_nx;
         if (finish) begin
            o_quot  <= dq_nx;
            o_rem   <= rem_nx;
            o_dzero <= bz_q;
         end
      end
   end

endmodule

// File: tb/tb_divr4_seq.sv
// Self-checking bench for divr4_seq (W=64, STAGES=4): vector table, random ops, back-to-back and reset sequences.
module tb_divr4_seq;

   localparam int W = 64;
   localparam int S = 4;
   localparam int N = W / (2 * S);

   logic         i_clk = 1'b0;
   logic         i_nrst;
   logic         i_ena;
   logic [W-1:0] i_a, i_b;
   logic         o_busy, o_valid, o_dzero;
   logic [W-1:0] o_quot, o_rem;

   divr4_seq #(.W(W), .STAGES(S)) dut (
      .i_clk(i_clk), .i_nrst(i_nrst), .i_ena(i_ena), .i_a(i_a), .i_b(i_b),
      .o_busy(o_busy), .o_valid(o_valid), .o_quot(o_quot), .o_rem(o_rem), .o_dzero(o_dzero)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           vcyc;
      int           nbusy;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } vec_t;

   exp_t sb[$];
   int   cyc = 0;
   int   busy_cnt = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
   endtask

   function automatic bit is_early(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIVR4_SEQ_EARLY_EXIT_EN
      return (b != '0) && (a < b);
`else
      return 1'b0;
`endif
   endfunction

   function automatic void push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] q, input logic [W-1:0] r,
                                    input logic dz, input int c0);
      exp_t e;
      e.q = q; e.r = r; e.dz = dz;
      e.vcyc  = is_early(a, b) ? c0 + 1 : c0 + N + 1;
      e.nbusy = is_early(a, b) ? 0 : N;
      sb.push_back(e);
   endfunction

   // Monitor: sample away from the active edge and score each result strobe.
   always @(negedge i_clk) begin
      if (!i_nrst) busy_cnt = 0;
      else begin
         if (o_busy) busy_cnt++;
         if (o_valid) begin
            if (sb.size() == 0) check("unexpected_valid", o_valid, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               check("quot", o_quot, e.q);
               check("rem", o_rem, e.r);
               check("dzero", o_dzero, e.dz);
               check("valid_cycle", cyc, e.vcyc);
               check("busy_cycles", busy_cnt, e.nbusy);
            end
            busy_cnt = 0;
         end else if (sb.size() != 0 && cyc > sb[0].vcyc) begin
            check("missing_valid", o_valid, 1);
            void'(sb.pop_front());
         end
      end
   end

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge i_clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      @(posedge i_clk);
   endtask

   // One request, then operands are scrambled after accept to show they no longer matter.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
      @(posedge i_clk); #1;
      i_ena = 1'b1; i_a = a; i_b = b;
      push_exp(a, b, q, r, dz, cyc);
      @(posedge i_clk); #1;
      i_ena = 1'b0; i_a = {$urandom(), $urandom()}; i_b = {$urandom(), $urandom()};
      wait_drain(4 * N);
   endtask

   vec_t vt[10];
   logic [W-1:0] ra, rb, eq, er;
   int c0;

   initial begin
      vt[0] = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0};
      vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
      vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0};
      vt[3] = '{64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1};
      vt[4] = '{64'd3, 64'd10, 64'd0, 64'd3, 1'b0};
      vt[5] = '{64'd81, 64'd9, 64'd9, 64'd0, 1'b0};
      vt[6] = '{64'd0, 64'd5, 64'd0, 64'd0, 1'b0};
      vt[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0};
      vt[8] = '{64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0};
      vt[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF, 64'h1_0000_0001, 64'd0, 1'b0};

      i_nrst = 1'b0; i_ena = 1'b0; i_a = '0; i_b = '0;
      #12;
      check("rst_busy", o_busy, 0);
      check("rst_valid", o_valid, 0);
      check("rst_quot", o_quot, 0);
      check("rst_rem", o_rem, 0);
      check("rst_dzero", o_dzero, 0);
      @(posedge i_clk); #1;
      i_nrst = 1'b1;

      for (int i = 0; i < 10; i++)
         run_op(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz);

      for (int i = 0; i < 16; i++) begin
         ra = {$urandom(), $urandom()};
         case (i % 4)
            0: rb = {$urandom(), $urandom()};
            1: rb = 64'($urandom_range(1, 1000));
            2: rb = {32'd0, $urandom()};
            default: rb = ra + 64'($urandom_range(1, 50));
         endcase
         eq = (rb == '0) ? '1 : ra / rb;
         er = (rb == '0) ? ra : ra % rb;
         run_op(ra, rb, eq, er, rb == '0);
      end

      // Back-to-back with i_ena held high; operand churn while busy must be ignored.
      @(posedge i_clk); #1;
      i_ena = 1'b1; i_a = 64'd100; i_b = 64'd7;
      c0 = cyc;
      push_exp(64'd100, 64'd7, 64'd14, 64'd2, 1'b0, c0);
      for (int k = 1; k <= N; k++) begin
         @(posedge i_clk); #1;
         i_a = {$urandom(), $urandom()}; i_b = {$urandom(), $urandom()};
      end
      @(posedge i_clk); #1;
      i_a = 64'd81; i_b = 64'd9;
      push_exp(64'd81, 64'd9, 64'd9, 64'd0, 1'b0, cyc);
      @(posedge i_clk); #1;
      i_ena = 1'b0;
      wait_drain(4 * N);

      // Divide-by-zero result must be held after the strobe.
      run_op(64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1);
      repeat (3) @(posedge i_clk);
      #1;
      check("hold_quot", o_quot, 64'hFFFF_FFFF_FFFF_FFFF);
      check("hold_rem", o_rem, 64'd5);
      check("hold_dzero", o_dzero, 1);
      check("hold_valid", o_valid, 0);

      // Asynchronous reset in cycle 4 of an operation.
      @(posedge i_clk); #1;
      i_ena = 1'b1; i_a = 64'd1000; i_b = 64'd3;
      push_exp(64'd1000, 64'd3, 64'd333, 64'd1, 1'b0, cyc);
      @(posedge i_clk); #1;
      i_ena = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      i_nrst = 1'b0;
      sb.delete();
      #1;
      check("abort_busy", o_busy, 0);
      check("abort_valid", o_valid, 0);
      check("abort_quot", o_quot, 0);
      check("abort_rem", o_rem, 0);
      check("abort_dzero", o_dzero, 0);
      repeat (2) @(posedge i_clk);
      #1;
      i_nrst = 1'b1;
      repeat (N + 2) @(posedge i_clk);
      run_op(64'd100, 64'd7, 64'd14, 64'd2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/divr4_seq.md
DIVR4_SEQ -- requirements
Module: divr4_seq

Interface
REQ-001 Parameter W, default 64: operand/result width; W SHALL be a multiple of 2*STAGES.
REQ-002 Parameter STAGES, default 4: radix-4 steps per clock (2*STAGES quotient bits per cycle).
REQ-003 i_clk  in  1  single clock, rising edge.
REQ-004 i_nrst  in  1  reset, asynchronous, active-low.
REQ-005 i_ena  in  1  start request; operands sampled when i_ena=1 and o_busy=0.
REQ-006 i_a  in  W  unsigned dividend.
REQ-007 i_b  in  W  unsigned divisor.
REQ-008 o_busy  out  1  division in progress; new requests ignored.
REQ-009 o_valid  out  1  one-cycle result strobe.
REQ-010 o_quot  out  W  quotient, held until next accept.
REQ-011 o_rem  out  W  remainder, held until next accept.
REQ-012 o_dzero  out  1  divide-by-zero flag, qualified by o_valid, held with results.

Function
REQ-013 Define N = W/(2*STAGES) iteration cycles; W=64, STAGES=4 gives N=8.
REQ-014 States SHALL be IDLE, ITER, DONE; reset state IDLE.
REQ-015 IDLE: on i_ena=1, SHALL latch i_a, i_b, clear partial remainder and counter, go to ITER (or DONE per REQ-027).
REQ-016 ITER: each cycle SHALL perform STAGES chained restoring radix-4 steps, MSB first; each step compares partial remainder against 3*b, 2*b, 1*b (widths W+2, MSB borrow test) and selects the largest non-negative difference, emitting digits 3/2/1/0.
REQ-017 Divisor multiples 2*b and 3*b SHALL be computed once at accept and registered, W+2 bits.
REQ-018 ITER SHALL last exactly N cycles, counter 0..N-1, then go to DONE.
REQ-019 DONE: o_valid=1 for exactly one cycle, o_busy=0, o_quot/o_rem updated; next state IDLE, or accept if i_ena=1 (back-to-back).
REQ-020 Latency: i_ena high in cycle 0 -> o_valid high in cycle N+1; o_busy high in cycles 1..N.
REQ-021 Throughput: one division per N+1 cycles with i_ena held high.
REQ-022 i_ena while o_busy=1 SHALL be ignored with no effect on the running operation.
REQ-023 Operand changes after accept SHALL not affect the result.
REQ-024 i_b=0: o_quot=all ones, o_rem=i_a, o_dzero=1, full latency unless REQ-027 applies; no special-case path beyond the flag.
REQ-025 Result SHALL satisfy a = q*b + r, r < b, for all b != 0.

Reset
REQ-026 i_nrst=0 at any time, including mid-ITER, SHALL immediately force IDLE, o_busy=0, o_valid=0, o_quot=0, o_rem=0, o_dzero=0, counter and partial remainder 0; the aborted operation produces no o_valid.

Configuration
REQ-027 Macro DIVR4_SEQ_EARLY_EXIT_EN: when defined, an accept with i_b!=0 and i_a<i_b SHALL bypass ITER: o_valid in cycle 1, o_quot=0, o_rem=i_a, o_busy never asserted; when undefined, all operations take N+1 cycles per REQ-020.

Verification
REQ-028 W=64,S=4: a=100, b=7 -> o_valid cycle 9, quot=14, rem=2, o_dzero=0.
REQ-029 a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> quot=a, rem=0; b=0x1_0000_0000 -> quot=0xFFFF_FFFF, rem=0xFFFF_FFFF.
REQ-030 a=5, b=0 -> quot=0xFFFF_FFFF_FFFF_FFFF, rem=5, o_dzero=1, o_valid cycle 9.
REQ-031 a=3, b=10: with macro -> o_valid cycle 1, quot=0, rem=3; without -> cycle 9, same values.
REQ-032 i_ena held high with a=100,b=7 then a=81,b=9 presented in cycle 9 -> o_valid cycles 9 and 18, second result quot=9, rem=0; operand changes in cycles 1-8 ignored.
REQ-033 i_nrst pulsed low in cycle 4 of an operation -> all outputs 0 asynchronously, no o_valid; next accept after reset release completes normally.
